ise_initiator: RTL and testbench

- Initiator side of the custom-instruction (ISE) interface. Accepts one request from a host (CPU-side shim or test sequencer) and issues it as a single `start` pulse to the responder ISEs, such as the Sobel ISE.
- Holds `iseId` and operands stable until `done` arrives or a timeout expires, then returns the result through a valid/ready response channel.
- Supports responders that answer combinationally in the start cycle and responders that answer multiple cycles later.

---
 rtl/ise_initiator_if.sv | 45 ++++
 rtl/ise_initiator.sv | 112 +++++++++++
 tb/tb_ise_initiator.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ise_initiator_if.sv
// +--------------------------------------------------------------------------+
// | ise_initiator_if : host request/response and ISE issue channel bundle.   |
// | Optional ISE_INITIATOR_LATENCY_EN adds rspLatency.  Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ise_initiator_if;
  logic        reqValid;
  logic        reqReady;
  logic [7:0]  reqIseId;
  logic [31:0] reqValueA;
  logic [31:0] reqValueB;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspResult;
  logic        rspTimeout;
  logic        iseStart;
  logic [7:0]  iseId;
  logic [31:0] iseValueA;
  logic [31:0] iseValueB;
  logic        iseDone;
  logic [31:0] iseResult;
`ifdef ISE_INITIATOR_LATENCY_EN
  logic [15:0] rspLatency;
`endif

  // master: the initiator itself; slave: host plus responders
  modport master (
`ifdef ISE_INITIATOR_LATENCY_EN
    output rspLatency,
`endif
    input  reqValid, reqIseId, reqValueA, reqValueB, rspReady, iseDone, iseResult,
    output reqReady, rspValid, rspResult, rspTimeout, iseStart, iseId, iseValueA, iseValueB
  );

  modport slave (
`ifdef ISE_INITIATOR_LATENCY_EN
    input  rspLatency,
`endif
    output reqValid, reqIseId, reqValueA, reqValueB, rspReady, iseDone, iseResult,
    input  reqReady, rspValid, rspResult, rspTimeout, iseStart, iseId, iseValueA, iseValueB
  );
endinterface

`default_nettype wire

// File: rtl/ise_initiator.sv
// +--------------------------------------------------------------------------+
// | ise_initiator : issues one host request to the ISE responders and        |
// | returns result or timeout. Option: ISE_INITIATOR_LATENCY_EN. Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module ise_initiator #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic            clock,
  input  logic            nReset,
  ise_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic [16:0] wait_num;
  logic        timeout_hit;
  logic        finish;

  // wait_num is the 1-based index of the current WAIT cycle
  assign wait_num    = {1'b0, wait_cnt} + 17'd1;
  assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (wait_num == {1'b0, TIMEOUT_CYCLES});
  assign finish      = bus.iseDone || ((state == WAIT) && timeout_hit);

`ifdef ISE_INITIATOR_LATENCY_EN
  logic [15:0] lat_k;
  assign lat_k = wait_num[16] ? 16'hFFFF : wait_num[15:0];
`endif

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state          <= IDLE;
      wait_cnt       <= 16'd0;
      bus.reqReady   <= 1'b0;
      bus.rspValid   <= 1'b0;
      bus.rspResult  <= 32'd0;
      bus.rspTimeout <= 1'b0;
      bus.iseStart   <= 1'b0;
      bus.iseId      <= 8'd0;
      bus.iseValueA  <= 32'd0;
      bus.iseValueB  <= 32'd0;
`ifdef ISE_INITIATOR_LATENCY_EN
      bus.rspLatency <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.reqValid && bus.reqReady) begin
            state         <= ISSUE;
            bus.reqReady  <= 1'b0;
            bus.iseStart  <= 1'b1;
            bus.iseId     <= bus.reqIseId;
            bus.iseValueA <= bus.reqValueA;
            bus.iseValueB <= bus.reqValueB;
          end else begin
            bus.reqReady  <= 1'b1;
          end
        end

        ISSUE, WAIT: begin
          bus.iseStart <= 1'b0;
          if (finish) begin
            // done wins over timeout when both land in the same cycle
            state          <= RESP;
            bus.rspValid   <= 1'b1;
            bus.rspResult  <= bus.iseDone ? bus.iseResult : 32'd0;
            bus.rspTimeout <= !bus.iseDone;
            bus.iseId      <= 8'd0;
            bus.iseValueA  <= 32'd0;
            bus.iseValueB  <= 32'd0;
`ifdef ISE_INITIATOR_LATENCY_EN
            bus.rspLatency <= (state == ISSUE) ? 16'd0 : lat_k;
`endif
          end else begin
            state <= WAIT;
            if (state == ISSUE) begin
              wait_cnt <= 16'd0;
            end else if (wait_cnt != 16'hFFFF) begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end
        end

        RESP: begin
          if (bus.rspReady) begin
            state          <= IDLE;
            bus.rspValid   <= 1'b0;
            bus.rspResult  <= 32'd0;
            bus.rspTimeout <= 1'b0;
            bus.reqReady   <= 1'b1;
`ifdef ISE_INITIATOR_LATENCY_EN
            bus.rspLatency <= 16'd0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ise_initiator.sv
// +--------------------------------------------------------------------------+
// | tb_ise_initiator : vector table, corner sequences and random traffic for |
// | two ise_initiator instances (timeout 255 and 4). Rev 1.0                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ise_initiator;

  typedef struct {
    int          d;
    logic [7:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] delay;
    logic [31:0] result;
    int          stall;
    int          exp_k;
    logic [31:0] exp_res;
    logic        exp_to;
    logic [15:0] exp_lat;
  } vec_t;

  logic clock = 1'b0;
  logic nReset = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // host-side drive and sampled outputs, indexed by instance
  logic        req_valid [2];
  logic [7:0]  req_id    [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic        rsp_ready [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_res   [2];
  logic        rsp_to    [2];
  logic        ise_start [2];
  logic [7:0]  ise_id    [2];
  logic [31:0] ise_a     [2];
  logic [31:0] ise_b     [2];
  logic        ise_done  [2];
  logic [31:0] ise_res   [2];
  logic [15:0] cfg_delay [2];
  logic [31:0] cfg_result[2];
  logic        rbusy     [2];
  logic [15:0] rcnt      [2];
`ifdef ISE_INITIATOR_LATENCY_EN
  logic [15:0] rsp_lat   [2];
`endif

  ise_initiator_if bus0();
  ise_initiator_if bus1();

  ise_initiator #(.TIMEOUT_CYCLES(16'd255)) dut0 (.clock(clock), .nReset(nReset), .bus(bus0));
  ise_initiator #(.TIMEOUT_CYCLES(16'd4))   dut1 (.clock(clock), .nReset(nReset), .bus(bus1));

  assign bus0.reqValid  = req_valid[0];
  assign bus0.reqIseId  = req_id[0];
  assign bus0.reqValueA = req_a[0];
  assign bus0.reqValueB = req_b[0];
  assign bus0.rspReady  = rsp_ready[0];
  assign bus0.iseDone   = ise_done[0];
  assign bus0.iseResult = ise_res[0];
  assign req_ready[0]   = bus0.reqReady;
  assign rsp_valid[0]   = bus0.rspValid;
  assign rsp_res[0]     = bus0.rspResult;
  assign rsp_to[0]      = bus0.rspTimeout;
  assign ise_start[0]   = bus0.iseStart;
  assign ise_id[0]      = bus0.iseId;
  assign ise_a[0]       = bus0.iseValueA;
  assign ise_b[0]       = bus0.iseValueB;

  assign bus1.reqValid  = req_valid[1];
  assign bus1.reqIseId  = req_id[1];
  assign bus1.reqValueA = req_a[1];
  assign bus1.reqValueB = req_b[1];
  assign bus1.rspReady  = rsp_ready[1];
  assign bus1.iseDone   = ise_done[1];
  assign bus1.iseResult = ise_res[1];
  assign req_ready[1]   = bus1.reqReady;
  assign rsp_valid[1]   = bus1.rspValid;
  assign rsp_res[1]     = bus1.rspResult;
  assign rsp_to[1]      = bus1.rspTimeout;
  assign ise_start[1]   = bus1.iseStart;
  assign ise_id[1]      = bus1.iseId;
  assign ise_a[1]       = bus1.iseValueA;
  assign ise_b[1]       = bus1.iseValueB;

`ifdef ISE_INITIATOR_LATENCY_EN
  assign rsp_lat[0] = bus0.rspLatency;
  assign rsp_lat[1] = bus1.rspLatency;
`endif

  // responder: done in the start cycle when delay is 0, else delay cycles after start
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      ise_done[d] = (ise_start[d] && cfg_delay[d] == 16'd0) ||
                    (rbusy[d] && rcnt[d] == cfg_delay[d]);
      ise_res[d]  = ise_done[d] ? cfg_result[d] : 32'hDEADBEEF;
    end
  end

  always @(posedge clock or negedge nReset) begin
    for (int d = 0; d < 2; d++) begin
      if (!nReset) begin
        rbusy[d] <= 1'b0;
        rcnt[d]  <= 16'd0;
      end else if (ise_start[d]) begin
        rbusy[d] <= (cfg_delay[d] != 16'd0);
        rcnt[d]  <= 16'd1;
      end else if (rbusy[d]) begin
        if (ise_done[d] || rsp_valid[d]) rbusy[d] <= 1'b0;
        rcnt[d] <= rcnt[d] + 16'd1;
      end
    end
  end

  function automatic logic [15:0] tmo_of(input int d);
    return (d == 0) ? 16'd255 : 16'd4;
  endfunction

  // reference: responder answers in WAIT cycle "delay" unless the timeout comes first
  function automatic void predict(input logic [15:0] tmo, input logic [15:0] delay,
                                  input logic [31:0] res, output int k,
                                  output logic [31:0] er, output logic eto,
                                  output logic [15:0] lat);
    if (tmo != 16'd0 && delay > tmo) begin
      k = int'(tmo); er = 32'd0; eto = 1'b1; lat = tmo;
    end else begin
      k = int'(delay); er = res; eto = 1'b0; lat = delay;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string name, input int d);
    check({name, "_rsp_valid"}, d, rsp_valid[d], 0);
    check({name, "_rsp_result"}, d, rsp_res[d], 0);
    check({name, "_rsp_timeout"}, d, rsp_to[d], 0);
    check({name, "_ise_start"}, d, ise_start[d], 0);
    check({name, "_ise_id"}, d, ise_id[d], 0);
    check({name, "_ise_a"}, d, ise_a[d], 0);
    check({name, "_ise_b"}, d, ise_b[d], 0);
`ifdef ISE_INITIATOR_LATENCY_EN
    check({name, "_rsp_latency"}, d, rsp_lat[d], 0);
`endif
  endtask

  task automatic run_txn(input vec_t v);
    int d;
    int guard;
    d = v.d;
    cfg_delay[d]  = v.delay;
    cfg_result[d] = v.result;
    guard = 0;
    while (!req_ready[d] && guard < 20) begin
      tick();
      guard++;
    end
    check("req_ready_idle", d, req_ready[d], 1);
    req_valid[d] = 1'b1;
    req_id[d]    = v.id;
    req_a[d]     = v.a;
    req_b[d]     = v.b;
    rsp_ready[d] = 1'b0;
    tick();
    req_valid[d] = 1'b0;
    req_id[d]    = 8'($urandom);
    req_a[d]     = $urandom;
    req_b[d]     = $urandom;
    for (int c = 1; c <= v.exp_k + 1; c++) begin
      check("ise_start", d, ise_start[d], (c == 1) ? 1 : 0);
      check("ise_id", d, ise_id[d], v.id);
      check("ise_a", d, ise_a[d], v.a);
      check("ise_b", d, ise_b[d], v.b);
      check("rsp_valid_early", d, rsp_valid[d], 0);
      check("req_ready_busy", d, req_ready[d], 0);
      tick();
    end
    for (int s = 0; s <= v.stall; s++) begin
      check("rsp_valid", d, rsp_valid[d], 1);
      check("rsp_result", d, rsp_res[d], v.exp_res);
      check("rsp_timeout", d, rsp_to[d], v.exp_to);
      check("resp_ise_start", d, ise_start[d], 0);
      check("resp_ise_id", d, ise_id[d], 0);
      check("resp_ise_a", d, ise_a[d], 0);
      check("resp_req_ready", d, req_ready[d], 0);
`ifdef ISE_INITIATOR_LATENCY_EN
      check("rsp_latency", d, rsp_lat[d], v.exp_lat);
`endif
      if (s == v.stall) begin
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
      end else begin
        req_valid[d] = 1'b1;
      end
      tick();
    end
    rsp_ready[d] = 1'b0;
    check("after_hs_rsp_valid", d, rsp_valid[d], 0);
    check("after_hs_rsp_result", d, rsp_res[d], 0);
    check("after_hs_req_ready", d, req_ready[d], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    vec_t v;
    tbl[0] = '{0, 8'd24,  32'h10,       32'h20,       16'd0,     32'h30,       0,  0, 32'h30,       1'b0, 16'd0};
    tbl[1] = '{0, 8'h5A,  32'h11111111, 32'h22222222, 16'd5,     32'hCAFEF00D, 0,  5, 32'hCAFEF00D, 1'b0, 16'd5};
    tbl[2] = '{1, 8'h03,  32'hA5A5A5A5, 32'h5A5A5A5A, 16'hFFFF,  32'h12345678, 0,  4, 32'h0,        1'b1, 16'd4};
    tbl[3] = '{1, 8'hFF,  32'hFFFFFFFF, 32'h0,        16'd4,     32'h0BADBEEF, 1,  4, 32'h0BADBEEF, 1'b0, 16'd4};
    tbl[4] = '{1, 8'h40,  32'h1,        32'h2,        16'd3,     32'h00000003, 0,  3, 32'h00000003, 1'b0, 16'd3};
    tbl[5] = '{0, 8'h81,  32'h80000000, 32'h7FFFFFFF, 16'd1,     32'h55AA55AA, 10, 1, 32'h55AA55AA, 1'b0, 16'd1};
    tbl[6] = '{1, 8'h00,  32'h0,        32'h0,        16'd0,     32'h87654321, 2,  0, 32'h87654321, 1'b0, 16'd0};

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b1;
      req_id[d]    = 8'hEE;
      req_a[d]     = 32'h1;
      req_b[d]     = 32'h2;
      rsp_ready[d] = 1'b0;
      cfg_delay[d] = 16'hFFFF;
      cfg_result[d] = 32'h0;
    end

    nReset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_quiet("reset", d);
      check("reset_req_ready", d, req_ready[d], 0);
    end
    nReset = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      check("post_reset_req_ready", d, req_ready[d], 1);
      check("post_reset_no_start", d, ise_start[d], 0);
      req_valid[d] = 1'b0;
    end
    tick();

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // reset landing in the middle of WAIT
    cfg_delay[0] = 16'hFFFF;
    req_valid[0] = 1'b1;
    req_id[0]    = 8'h77;
    req_a[0]     = 32'hABCD0123;
    req_b[0]     = 32'h3210DCBA;
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    check("wait_hold_id", 0, ise_id[0], 8'h77);
    check("wait_hold_a", 0, ise_a[0], 32'hABCD0123);
    #2 nReset = 1'b0;
    #1;
    check_quiet("async_reset", 0);
    check("async_reset_req_ready", 0, req_ready[0], 0);
    #1 nReset = 1'b1;
    repeat (6) begin
      tick();
      check("post_abort_rsp_valid", 0, rsp_valid[0], 0);
      check("post_abort_ise_start", 0, ise_start[0], 0);
    end
    check("post_abort_req_ready", 0, req_ready[0], 1);

    for (int i = 0; i < 40; i++) begin
      v.d      = int'($urandom_range(0, 1));
      v.id     = 8'($urandom);
      v.a      = $urandom;
      v.b      = $urandom;
      v.result = $urandom;
      v.stall  = int'($urandom_range(0, 3));
      if (v.d == 1 && $urandom_range(0, 7) == 0) v.delay = 16'hFFFF;
      else v.delay = 16'($urandom_range(0, (v.d == 0) ? 12 : 7));
      predict(tmo_of(v.d), v.delay, v.result, v.exp_k, v.exp_res, v.exp_to, v.exp_lat);
      run_txn(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
